// File: rtl/button_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : button_conditioner                                           |
// | Description : Board-input front end. Synchronises and debounces the five   |
// |               push buttons and sixteen slide switches. Each input is its   |
// |               own channel. Outputs are clean levels plus single-cycle      |
// |               press / release / auto-repeat strobes for buttons and an     |
// |               any-switch-changed strobe.                                   |
// | Ports       : clock_100mhz      in   system clock, rising edge            |
// |               reset             in   synchronous, active-high             |
// |               buttons_raw       in   async button pads (c/u/r/d/l)        |
// |               switches_raw      in   async switch pads [15:0]             |
// |               buttons           out  debounced button levels              |
// |               buttons_pressed   out  1-cycle strobe on debounced 0->1     |
// |               buttons_released  out  1-cycle strobe on debounced 1->0     |
// |               buttons_repeat    out  strobe on press and each repeat tick |
// |               switches          out  debounced switch levels              |
// |               switches_changed  out  1-cycle strobe, any switch changed   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+

package button_conditioner_pkg;
  // Field order fixes the packed bit positions: center=4 ... left=0.
  typedef struct packed {
    logic center;
    logic up;
    logic right;
    logic down;
    logic left;
  } buttons_t;
endpackage

module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES          = 2,
  parameter int DEBOUNCE_CYCLES      = 1_000_000,
  parameter int REPEAT_ENABLE        = 1,
  parameter int REPEAT_DELAY_CYCLES  = 50_000_000,
  parameter int REPEAT_PERIOD_CYCLES = 10_000_000
) (
  input  logic        clock_100mhz,
  input  logic        reset,
  input  buttons_t    buttons_raw,
  input  logic [15:0] switches_raw,
  output buttons_t    buttons,
  output buttons_t    buttons_pressed,
  output buttons_t    buttons_released,
  output buttons_t    buttons_repeat,
  output logic [15:0] switches,
  output logic        switches_changed
);

  localparam int NUM_BTN = 5;
  localparam int NUM_SW  = 16;
  localparam int NUM_CH  = NUM_BTN + NUM_SW;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                           REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD_CYCLES - 1);

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  // Channel map: buttons occupy bits [4:0], switches bits [20:5].
  logic [NUM_CH-1:0]  w_raw;
  logic [NUM_CH-1:0]  r_sync [SYNC_STAGES];
  logic [NUM_CH-1:0]  w_sync_out;
  logic [NUM_CH-1:0]  w_accept;
  logic [NUM_CH-1:0]  r_level;

  logic [NUM_BTN-1:0] w_btn_press;
  logic [NUM_BTN-1:0] w_btn_release;
  logic [NUM_BTN-1:0] w_rpt_tick;

  logic [NUM_BTN-1:0] r_pressed;
  logic [NUM_BTN-1:0] r_released;
  logic [NUM_BTN-1:0] r_repeat;
  logic               r_sw_changed;

  assign w_raw = {switches_raw, buttons_raw};

  // ---------------------------------------------------------------------------
  // Synchroniser chain, all channels in parallel.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_100mhz) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= w_raw;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce counters, one per channel. A change is accepted on the
  // DEBOUNCE_CYCLES-th consecutive sample that disagrees with the level; any
  // agreeing sample in between restarts the count.
  // ---------------------------------------------------------------------------
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_db
    logic [DB_W-1:0] r_cnt;

    assign w_accept[ch] = (w_sync_out[ch] != r_level[ch]) && (r_cnt == DB_LAST);

    always_ff @(posedge clock_100mhz) begin
      if (reset) begin
        r_cnt <= '0;
      end else if ((w_sync_out[ch] == r_level[ch]) || w_accept[ch]) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign w_btn_press   = w_accept[NUM_BTN-1:0] &  w_sync_out[NUM_BTN-1:0];
  assign w_btn_release = w_accept[NUM_BTN-1:0] & ~w_sync_out[NUM_BTN-1:0];

  // ---------------------------------------------------------------------------
  // Auto-repeat FSM per button. The press strobe itself is the first repeat
  // strobe; the FSM only supplies the later ticks. A release on the same edge
  // as a tick wins, so no repeat strobe accompanies a release.
  // ---------------------------------------------------------------------------
  if (REPEAT_ENABLE != 0) begin : g_repeat
    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
      rpt_state_t       r_state;
      rpt_state_t       w_state_nxt;
      logic [RPT_W-1:0] r_cnt;
      logic [RPT_W-1:0] w_cnt_nxt;
      logic             w_tick;

      always_ff @(posedge clock_100mhz) begin
        if (reset) begin
          r_state <= RPT_IDLE;
          r_cnt   <= '0;
        end else begin
          r_state <= w_state_nxt;
          r_cnt   <= w_cnt_nxt;
        end
      end

      always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tick      = 1'b0;
        case (r_state)
          RPT_IDLE: begin
            if (w_btn_press[b]) begin
              w_state_nxt = RPT_DELAY;
              w_cnt_nxt   = '0;
            end
          end
          RPT_DELAY: begin
            if (w_btn_release[b]) begin
              w_state_nxt = RPT_IDLE;
              w_cnt_nxt   = '0;
            end else if (r_cnt == RPT_DELAY_LAST) begin
              w_tick      = 1'b1;
              w_state_nxt = RPT_REPEAT;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt   = r_cnt + 1'b1;
            end
          end
          RPT_REPEAT: begin
            if (w_btn_release[b]) begin
              w_state_nxt = RPT_IDLE;
              w_cnt_nxt   = '0;
            end else if (r_cnt == RPT_PERIOD_LAST) begin
              w_tick      = 1'b1;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt   = r_cnt + 1'b1;
            end
          end
          default: begin
            w_state_nxt = RPT_IDLE;
            w_cnt_nxt   = '0;
          end
        endcase
      end

      assign w_rpt_tick[b] = w_tick;
    end
  end else begin : g_no_repeat
    assign w_rpt_tick = '0;
  end

  // ---------------------------------------------------------------------------
  // Levels and strobes. An accepted change always differs from the current
  // level, so the level update is a toggle of the accepted bits.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_100mhz) begin
    if (reset) begin
      r_level      <= '0;
      r_pressed    <= '0;
      r_released   <= '0;
      r_repeat     <= '0;
      r_sw_changed <= 1'b0;
    end else begin
      r_level      <= r_level ^ w_accept;
      r_pressed    <= w_btn_press;
      r_released   <= w_btn_release;
      r_repeat     <= w_btn_press | w_rpt_tick;
      r_sw_changed <= |w_accept[NUM_CH-1:NUM_BTN];
    end
  end

  assign buttons          = buttons_t'(r_level[NUM_BTN-1:0]);
  assign buttons_pressed  = buttons_t'(r_pressed);
  assign buttons_released = buttons_t'(r_released);
  assign buttons_repeat   = buttons_t'(r_repeat);
  assign switches         = r_level[NUM_CH-1:NUM_BTN];
  assign switches_changed = r_sw_changed;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_button_conditioner                                        |
// | Description : Directed self-checking bench for button_conditioner with     |
// |               SYNC_STAGES=2, DEBOUNCE_CYCLES=4, DELAY=20, PERIOD=5.        |
// |               Inputs change and outputs are checked 1 ns after the falling |
// |               edge; a falling-edge monitor logs strobes by edge number.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_button_conditioner;
  import button_conditioner_pkg::*;

  localparam int C = 4, U = 3, R = 2, D = 1, L = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  btn_raw;
  logic [15:0] sw_raw;
  logic [4:0]  btn, pressed, released, rpt;
  logic [15:0] switches;
  logic        sw_changed;

  always #5 clk = ~clk;

  button_conditioner #(
    .SYNC_STAGES          (2),
    .DEBOUNCE_CYCLES      (4),
    .REPEAT_ENABLE        (1),
    .REPEAT_DELAY_CYCLES  (20),
    .REPEAT_PERIOD_CYCLES (5)
  ) dut (
    .clock_100mhz     (clk),
    .reset            (reset),
    .buttons_raw      (btn_raw),
    .switches_raw     (sw_raw),
    .buttons          (btn),
    .buttons_pressed  (pressed),
    .buttons_released (released),
    .buttons_repeat   (rpt),
    .switches         (switches),
    .switches_changed (sw_changed)
  );

  // Edge counter: at the falling edge after rising edge N it reads N.
  int edge_no = 0;
  always @(posedge clk) edge_no <= edge_no + 1;

  // Strobe log.
  int p_cnt [5];
  int p_last[5];
  int r_cnt [5];
  int r_last[5];
  int rep_n [5];
  int rep_t [5][16];
  int sc_cnt, sc_last, both_cnt;

  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 5; i++) begin
        if (pressed[i])  begin p_cnt[i]++; p_last[i] = edge_no; end
        if (released[i]) begin r_cnt[i]++; r_last[i] = edge_no; end
        if (pressed[i] && released[i]) both_cnt++;
        if (rpt[i]) begin
          if (rep_n[i] < 16) rep_t[i][rep_n[i]] = edge_no;
          rep_n[i]++;
        end
      end
      if (sw_changed) begin sc_cnt++; sc_last = edge_no; end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_out();
    return {27'd0, btn, pressed, released, rpt, switches, sw_changed};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 5; i++) begin
      p_cnt[i] = 0; p_last[i] = -1; r_cnt[i] = 0; r_last[i] = -1; rep_n[i] = 0;
      for (int k = 0; k < 16; k++) rep_t[i][k] = -1;
    end
    sc_cnt = 0; sc_last = -1;
  endtask

  // Holds reset for n edges (raw inputs untouched), checks outputs stay 0,
  // then releases it. The last reset edge is "edge 0" for the caller.
  task automatic apply_reset(input int n);
    reset = 1'b1;
    for (int k = 0; k < n; k++) begin
      step();
      check("reset_outputs_zero", all_out(), 64'd0);
    end
    reset = 1'b0;
    clear_mon();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int e0, p;

  initial begin
    both_cnt = 0;
    clear_mon();
    reset   = 1'b1;
    btn_raw = 5'd0;
    sw_raw  = 16'd0;

    // 1. up held through reset -> normal press after full latency.
    btn_raw[U] = 1'b1;
    apply_reset(3);
    e0 = edge_no;
    repeat (5) step();
    check("t1_up_level_before_6", btn[U], 1'b0);
    check("t1_no_press_before_6", p_cnt[U], 0);
    step();
    check("t1_up_level_at_6", btn[U], 1'b1);
    check("t1_up_pressed_at_6", pressed, 5'b01000);
    check("t1_up_repeat_at_6", rpt, 5'b01000);
    check("t1_edge_is_6", edge_no - e0, 6);
    step();
    check("t1_pressed_one_cycle", pressed[U], 1'b0);
    check("t1_level_held", btn[U], 1'b1);
    btn_raw[U] = 1'b0;
    repeat (10) step();
    check("t1_up_released_once", r_cnt[U], 1);
    check("t1_up_level_low", btn[U], 1'b0);

    // 2. Bouncing center: two-sample pulses never qualify.
    apply_reset(2);
    for (int k = 0; k < 4; k++) begin
      btn_raw[C] = (k % 2 == 0);
      repeat (2) step();
    end
    btn_raw[C] = 1'b1;
    e0 = edge_no;
    repeat (5) step();
    check("t2_no_press_during_bounce", p_cnt[C], 0);
    step();
    check("t2_pressed_after_6", pressed[C], 1'b1);
    repeat (8) step();
    check("t2_single_press", p_cnt[C], 1);
    check("t2_press_edge", p_last[C] - e0, 6);
    check("t2_no_release", r_cnt[C], 0);
    btn_raw[C] = 1'b0;

    // 3. left held: repeats at P, P+20, P+25, P+30, P+35; level drops at P+38.
    apply_reset(2);
    btn_raw[L] = 1'b1;
    p = edge_no + 6;
    repeat (38) step();
    btn_raw[L] = 1'b0;
    repeat (30) step();
    check("t3_repeat_count", rep_n[L], 5);
    check("t3_repeat0", rep_t[L][0] - p, 0);
    check("t3_repeat1", rep_t[L][1] - p, 20);
    check("t3_repeat2", rep_t[L][2] - p, 25);
    check("t3_repeat3", rep_t[L][3] - p, 30);
    check("t3_repeat4", rep_t[L][4] - p, 35);
    check("t3_release_count", r_cnt[L], 1);
    check("t3_release_edge", r_last[L] - p, 38);
    check("t3_press_count", p_cnt[L], 1);

    // 4. Switch word change, then a 3-sample glitch on bit 0.
    apply_reset(2);
    sw_raw = 16'hA5A5;
    repeat (5) step();
    check("t4_switches_before_6", switches, 16'h0000);
    step();
    check("t4_switches_at_6", switches, 16'hA5A5);
    check("t4_changed_at_6", sw_changed, 1'b1);
    step();
    check("t4_changed_one_cycle", sw_changed, 1'b0);
    sw_raw[0] = 1'b0;
    repeat (3) step();
    sw_raw[0] = 1'b1;
    repeat (20) step();
    check("t4_glitch_ignored", switches, 16'hA5A5);
    check("t4_changed_count", sc_cnt, 1);

    // 5. Reset two cycles into the up debounce, raw stays high.
    apply_reset(2);
    btn_raw[U] = 1'b1;
    repeat (2) step();
    apply_reset(2);
    e0 = edge_no;
    repeat (5) step();
    check("t5_no_early_press", p_cnt[U], 0);
    check("t5_level_low_before_6", btn[U], 1'b0);
    step();
    check("t5_pressed_at_6", pressed[U], 1'b1);
    step();
    check("t5_press_edge", p_last[U] - e0, 6);
    btn_raw[U] = 1'b0;

    // 6. down and right together; right released early, down keeps going.
    apply_reset(2);
    btn_raw[D] = 1'b1;
    btn_raw[R] = 1'b1;
    p = edge_no + 6;
    repeat (6) step();
    check("t6_both_pressed", pressed, 5'b00110);
    check("t6_both_repeat", rpt, 5'b00110);
    repeat (21) step();
    btn_raw[R] = 1'b0;
    repeat (16) step();
    btn_raw[D] = 1'b0;
    repeat (20) step();
    check("t6_right_repeat_count", rep_n[R], 3);
    check("t6_right_repeat2", rep_t[R][2] - p, 25);
    check("t6_right_release_edge", r_last[R] - p, 27);
    check("t6_down_repeat_count", rep_n[D], 6);
    check("t6_down_repeat3", rep_t[D][3] - p, 30);
    check("t6_down_repeat5", rep_t[D][5] - p, 40);
    check("t6_down_release_edge", r_last[D] - p, 43);

    check("press_release_exclusive", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
